// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Final writeback stage ahead of the register file. Merges the in-order
//   pipeline result and out-of-order multi-cycle (mul/div) results onto the
//   register file's single synchronous write port. Multi-cycle results wait
//   in a small FIFO. A per-register busy scoreboard is kept for decode. A
//   stall request is raised when continuous pipeline writes starve the FIFO.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   pipe_wb_valid/sel/data           pipeline result for this cycle
//   mc_issue_valid/sel               multi-cycle issue, reserves destination
//   mc_result_valid/sel/data         multi-cycle result offer
//   mc_result_ready                  FIFO can accept this cycle
//   busy_mask                        per-register pending multi-cycle write
//   stall_req                        pipeline must hold its writeback
//   rf_write_en/sel/data             registered register-file write port
module writeback_arbiter #(
  parameter int NUM_REGS     = 16,
  parameter int SEL_WIDTH    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_wb_valid,
  input  logic [SEL_WIDTH-1:0]  pipe_wb_sel,
  input  logic [DATA_WIDTH-1:0] pipe_wb_data,
  input  logic                  mc_issue_valid,
  input  logic [SEL_WIDTH-1:0]  mc_issue_sel,
  input  logic                  mc_result_valid,
  input  logic [SEL_WIDTH-1:0]  mc_result_sel,
  input  logic [DATA_WIDTH-1:0] mc_result_data,
  output logic                  mc_result_ready,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  stall_req,
  output logic                  rf_write_en,
  output logic [SEL_WIDTH-1:0]  rf_write_sel,
  output logic [DATA_WIDTH-1:0] rf_write_data
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [SEL_WIDTH-1:0]  sel_mem  [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W:0]        count;
  logic [CNT_W-1:0]      starve_cnt;
  logic [CNT_W-1:0]      starve_next;

  logic                  fifo_empty;
  logic                  pipe_eff;
  logic                  pop;
  logic                  push;
  logic [SEL_WIDTH-1:0]  head_sel;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;

  assign fifo_empty = (count == '0);
  assign head_sel   = sel_mem[head];
  assign head_data  = data_mem[head];

  // Ready looks only at the current occupancy; a pop in the same cycle does
  // not open a slot early. Held low while in reset.
  assign mc_result_ready = rst_n && (count != FULL_COUNT);

  // A write to register 0 never occupies the port, and while stalled the
  // pipeline input is ignored so the FIFO drains.
  assign pipe_eff = pipe_wb_valid && (pipe_wb_sel != '0) && !stall_req;
  assign pop      = !pipe_eff && !fifo_empty;
  // Results for register 0 complete the handshake but are dropped.
  assign push     = mc_result_valid && mc_result_ready && (mc_result_sel != '0);

  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_empty) begin
      starve_next = '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_next = starve_cnt + CNT_W'(1);
    end
  end

  // Scoreboard edits: clearing is applied first so a same-cycle issue wins.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (mc_issue_valid && (mc_issue_sel != '0)) begin
      set_vec[mc_issue_sel] = 1'b1;
    end
    if (pop) begin
      clr_vec[head_sel] = 1'b1;
    end
  end

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      sel_mem[tail]  <= mc_result_sel;
      data_mem[tail] <= mc_result_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      starve_cnt    <= '0;
      stall_req     <= 1'b0;
      busy_mask     <= '0;
      rf_write_en   <= 1'b0;
      rf_write_sel  <= '0;
      rf_write_data <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W + 1)'(1);
      end

      starve_cnt <= starve_next;
      // Set when starvation hits the limit; released once the FIFO has been
      // observed empty, i.e. the edge after the last pop.
      if (starve_next == STARVE_MAX) begin
        stall_req <= 1'b1;
      end else if (stall_req && fifo_empty) begin
        stall_req <= 1'b0;
      end

      busy_mask <= (busy_mask & ~clr_vec) | set_vec;

      // Without a source the enable drops while sel/data keep their value.
      rf_write_en <= pipe_eff || pop;
      if (pipe_eff) begin
        rf_write_sel  <= pipe_wb_sel;
        rf_write_data <= pipe_wb_data;
      end else if (pop) begin
        rf_write_sel  <= head_sel;
        rf_write_data <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//   Self-checking bench for writeback_arbiter. A queue-based reference model
//   predicts the register-file write, scoreboard, stall and ready outputs.
//   Directed scenarios cover pipeline writes, the multi-cycle path, FIFO
//   full, starvation, same-cycle set/clear and reset mid-operation, followed
//   by a randomized run.
module tb_writeback_arbiter;

  localparam int NUM_REGS     = 16;
  localparam int SEL_WIDTH    = 4;
  localparam int DATA_WIDTH   = 32;
  localparam int BUF_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  pipe_wb_valid;
  logic [SEL_WIDTH-1:0]  pipe_wb_sel;
  logic [DATA_WIDTH-1:0] pipe_wb_data;
  logic                  mc_issue_valid;
  logic [SEL_WIDTH-1:0]  mc_issue_sel;
  logic                  mc_result_valid;
  logic [SEL_WIDTH-1:0]  mc_result_sel;
  logic [DATA_WIDTH-1:0] mc_result_data;
  logic                  mc_result_ready;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  stall_req;
  logic                  rf_write_en;
  logic [SEL_WIDTH-1:0]  rf_write_sel;
  logic [DATA_WIDTH-1:0] rf_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .NUM_REGS(NUM_REGS), .SEL_WIDTH(SEL_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .BUF_DEPTH(BUF_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_sel(pipe_wb_sel), .pipe_wb_data(pipe_wb_data),
    .mc_issue_valid(mc_issue_valid), .mc_issue_sel(mc_issue_sel),
    .mc_result_valid(mc_result_valid), .mc_result_sel(mc_result_sel),
    .mc_result_data(mc_result_data), .mc_result_ready(mc_result_ready),
    .busy_mask(busy_mask), .stall_req(stall_req),
    .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data)
  );

  // Reference model: pending results as a queue, scoreboard as a bit vector,
  // starvation as a plain integer count of blocked cycles.
  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mq[$];
  logic [NUM_REGS-1:0]   m_busy;
  int                    m_starve;
  logic                  m_stall;
  logic                  m_en;
  logic [SEL_WIDTH-1:0]  m_sel;
  logic [DATA_WIDTH-1:0] m_data;

  task automatic model_reset();
    mq.delete();
    m_busy   = '0;
    m_starve = 0;
    m_stall  = 1'b0;
    m_en     = 1'b0;
    m_sel    = '0;
    m_data   = '0;
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int     pre_size;
    bit     pipe_go;
    bit     room;
    bit     popped;
    entry_t e;
    entry_t n;
    pre_size = mq.size();
    pipe_go  = pipe_wb_valid && (pipe_wb_sel != 0) && !m_stall;
    room     = (pre_size < BUF_DEPTH);
    popped   = 1'b0;
    if (pipe_go) begin
      m_en   = 1'b1;
      m_sel  = pipe_wb_sel;
      m_data = pipe_wb_data;
    end else if (pre_size > 0) begin
      e      = mq.pop_front();
      popped = 1'b1;
      m_en   = 1'b1;
      m_sel  = e.sel;
      m_data = e.data;
      m_busy[e.sel] = 1'b0;
    end else begin
      m_en = 1'b0;
    end
    if (mc_issue_valid && (mc_issue_sel != 0)) m_busy[mc_issue_sel] = 1'b1;
    if (mc_result_valid && room && (mc_result_sel != 0)) begin
      n.sel  = mc_result_sel;
      n.data = mc_result_data;
      mq.push_back(n);
    end
    if (popped || pre_size == 0) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
    if (m_starve == STARVE_LIMIT) m_stall = 1'b1;
    else if (m_stall && pre_size == 0) m_stall = 1'b0;
  endtask

  task automatic drive(input logic pv, input logic [3:0] psel, input logic [31:0] pdata,
                       input logic iv, input logic [3:0] isel,
                       input logic rv, input logic [3:0] rsel, input logic [31:0] rdata);
    pipe_wb_valid   = pv;
    pipe_wb_sel     = psel;
    pipe_wb_data    = pdata;
    mc_issue_valid  = iv;
    mc_issue_sel    = isel;
    mc_result_valid = rv;
    mc_result_sel   = rsel;
    mc_result_data  = rdata;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Drains leftover state from an earlier scenario.
  task automatic settle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8 && (mq.size() != 0 || m_stall); i++) tick();
    tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data, busy_mask, stall_req, mc_result_ready} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state en=%b sel=%h data=%h busy=%h stall=%b ready=%b, want all 0",
               rf_write_en, rf_write_sel, rf_write_data, busy_mask, stall_req, mc_result_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (mc_result_ready !== 1'b1 || rf_write_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release ready=%b en=%b, want ready=1 en=0", mc_result_ready, rf_write_en);
    end
  endtask

  task automatic test_pipeline();
    drive(1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (rf_write_en !== 1'b1 || rf_write_sel !== 4'd5 || rf_write_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL pipe_write en=%b sel=%0d data=%h, want en=1 sel=5 data=deadbeef",
               rf_write_en, rf_write_sel, rf_write_data);
    end
    drive(1, 4'd0, 32'h0000AAAA, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (rf_write_en !== 1'b0 || rf_write_sel !== 4'd5 || rf_write_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL pipe_reg0 en=%b sel=%0d data=%h, want en=0 sel=5 data=deadbeef (held)",
               rf_write_en, rf_write_sel, rf_write_data);
    end
  endtask

  task automatic test_multicycle();
    drive(0, 0, 0, 1, 4'd3, 0, 0, 0);
    tick();
    n_checks++;
    if (busy_mask !== 16'h0008) begin
      n_fail++;
      $display("[TB] FAIL mc_issue busy=%h, want 0008", busy_mask);
    end
    drive(0, 0, 0, 0, 0, 1, 4'd3, 32'h12345678);
    tick();
    n_checks++;
    if (rf_write_en !== 1'b0 || busy_mask !== 16'h0008) begin
      n_fail++;
      $display("[TB] FAIL mc_no_bypass en=%b busy=%h, want en=0 busy=0008", rf_write_en, busy_mask);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (rf_write_en !== 1'b1 || rf_write_sel !== 4'd3 || rf_write_data !== 32'h12345678 ||
        busy_mask !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL mc_write en=%b sel=%0d data=%h busy=%h, want en=1 sel=3 data=12345678 busy=0000",
               rf_write_en, rf_write_sel, rf_write_data, busy_mask);
    end
  endtask

  task automatic test_fifo_full();
    logic exp_ready;
    drive(1, 4'd1, $urandom, 0, 0, 1, 4'd9, 32'hA0A0A0A0);
    tick();
    drive(1, 4'd1, $urandom, 0, 0, 1, 4'd10, 32'hB0B0B0B0);
    tick();
    n_checks++;
    if (mc_result_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fifo_full_ready ready=%b, want 0", mc_result_ready);
    end
    drive(1, 4'd1, 32'h11111111, 0, 0, 1, 4'd11, 32'hC0C0C0C0);
    tick();
    n_checks++;
    if (rf_write_en !== 1'b1 || rf_write_sel !== 4'd1 || rf_write_data !== 32'h11111111 ||
        mc_result_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fifo_full_hold en=%b sel=%0d data=%h ready=%b, want en=1 sel=1 data=11111111 ready=0",
               rf_write_en, rf_write_sel, rf_write_data, mc_result_ready);
    end
    drive(0, 0, 0, 0, 0, 1, 4'd11, 32'hC0C0C0C0);
    tick();
    n_checks++;
    if (rf_write_sel !== 4'd9 || rf_write_data !== 32'hA0A0A0A0 || mc_result_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL fifo_one_pop sel=%0d data=%h ready=%b, want sel=9 data=a0a0a0a0 ready=1",
               rf_write_sel, rf_write_data, mc_result_ready);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(0, 0, 0, 0, 0, 1, 4'd11, 32'hC0C0C0C0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0);
      exp_ready = (mq.size() < BUF_DEPTH);
      n_checks++;
      if (mc_result_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL fifo_drain_ready[%0d] ready=%b, want %b", i, mc_result_ready, exp_ready);
      end
      tick();
      n_checks++;
      if (rf_write_en !== m_en || rf_write_sel !== m_sel || rf_write_data !== m_data) begin
        n_fail++;
        $display("[TB] FAIL fifo_drain[%0d] en=%b sel=%0d data=%h, want en=%b sel=%0d data=%h",
                 i, rf_write_en, rf_write_sel, rf_write_data, m_en, m_sel, m_data);
      end
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 10; i++) begin
      case (i)
        0:       drive(1, 4'd2, $urandom, 0, 0, 1, 4'd4, 32'h44440000);
        1:       drive(1, 4'd2, $urandom, 0, 0, 1, 4'd5, 32'h55550000);
        default: drive(1, 4'd2, 32'h0BAD0000 + i, 0, 0, 0, 0, 0);
      endcase
      tick();
      n_checks++;
      if (rf_write_en !== m_en || rf_write_sel !== m_sel || rf_write_data !== m_data ||
          stall_req !== m_stall || busy_mask !== m_busy) begin
        n_fail++;
        $display("[TB] FAIL starve_cycle[%0d] en=%b sel=%0d data=%h stall=%b busy=%h, want en=%b sel=%0d data=%h stall=%b busy=%h",
                 i, rf_write_en, rf_write_sel, rf_write_data, stall_req, busy_mask,
                 m_en, m_sel, m_data, m_stall, m_busy);
      end
      if (i == 3) begin
        n_checks++;
        if (stall_req !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL starve_before_limit stall=%b, want 0", stall_req);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (stall_req !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL starve_at_limit stall=%b, want 1", stall_req);
        end
      end
      if (i == 5 || i == 6) begin
        n_checks++;
        if (rf_write_sel !== ((i == 5) ? 4'd4 : 4'd5) || rf_write_data[31:16] !== ((i == 5) ? 16'h4444 : 16'h5555)) begin
          n_fail++;
          $display("[TB] FAIL starve_drain_order[%0d] sel=%0d data=%h", i, rf_write_sel, rf_write_data);
        end
      end
      if (i == 7) begin
        n_checks++;
        if (stall_req !== 1'b0 || rf_write_en !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL starve_release stall=%b en=%b, want stall=0 en=0", stall_req, rf_write_en);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    settle();
    drive(0, 0, 0, 1, 4'd7, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 4'd7, 32'h77777777);
    tick();
    drive(0, 0, 0, 1, 4'd7, 0, 0, 0);
    tick();
    n_checks++;
    if (rf_write_en !== 1'b1 || rf_write_sel !== 4'd7 || busy_mask[7] !== 1'b1 || busy_mask !== m_busy) begin
      n_fail++;
      $display("[TB] FAIL set_wins en=%b sel=%0d busy=%h, want en=1 sel=7 busy=%h",
               rf_write_en, rf_write_sel, busy_mask, m_busy);
    end
  endtask

  task automatic test_random();
    logic exp_ready;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 99) < 25, 4'($urandom_range(0, 15)),
            $urandom_range(0, 99) < 45, 4'($urandom_range(0, 15)), $urandom);
      exp_ready = (mq.size() < BUF_DEPTH);
      n_checks++;
      if (mc_result_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL rand_ready[%0d] ready=%b, want %b", i, mc_result_ready, exp_ready);
      end
      tick();
      n_checks++;
      if (rf_write_en !== m_en || rf_write_sel !== m_sel || rf_write_data !== m_data ||
          stall_req !== m_stall || busy_mask !== m_busy) begin
        n_fail++;
        $display("[TB] FAIL rand_cycle[%0d] en=%b sel=%0d data=%h stall=%b busy=%h, want en=%b sel=%0d data=%h stall=%b busy=%h",
                 i, rf_write_en, rf_write_sel, rf_write_data, stall_req, busy_mask,
                 m_en, m_sel, m_data, m_stall, m_busy);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 4'd6, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 4'd7, 0, 0, 0);
    tick();
    drive(1, 4'd1, $urandom, 0, 0, 1, 4'd6, $urandom);
    tick();
    drive(1, 4'd1, $urandom, 0, 0, 1, 4'd7, $urandom);
    tick();
    n_checks++;
    if (busy_mask !== 16'h00C0 || mc_result_ready !== 1'b0 || mq.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL midreset_setup busy=%h ready=%b, want busy=00c0 ready=0", busy_mask, mc_result_ready);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({rf_write_en, rf_write_sel, rf_write_data, busy_mask, stall_req, mc_result_ready} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_async en=%b sel=%h data=%h busy=%h stall=%b ready=%b, want all 0",
               rf_write_en, rf_write_sel, rf_write_data, busy_mask, stall_req, mc_result_ready);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rf_write_en !== 1'b0 || busy_mask !== 16'h0000 || mc_result_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL midreset_after[%0d] en=%b busy=%h ready=%b, want en=0 busy=0000 ready=1",
                 i, rf_write_en, busy_mask, mc_result_ready);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout, simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_pipeline();
    test_multicycle();
    test_fifo_full();
    settle();
    test_starvation();
    test_same_cycle();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Final writeback stage directly upstream of the register file. Merges two producers onto the file's single synchronous write port: the in-order pipeline result and out-of-order multi-cycle (mul/div) results.
- Multi-cycle results are held in a small FIFO.
- Keeps a per-register busy scoreboard for the decode stage.
- Raises a stall request when the FIFO is starved by continuous pipeline writes.

Parameters:
- NUM_REGS, 16, number of architectural registers; register 0 is hardwired zero.
- SEL_WIDTH, 4, register select width, log2(NUM_REGS).
- DATA_WIDTH, 32, register data width.
- BUF_DEPTH, 2, multi-cycle result FIFO depth; power of two, at least 2.
- STARVE_LIMIT, 4, number of consecutive blocked-pop cycles before stall_req is raised.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_wb_valid  in  1  pipeline result present this cycle.
- pipe_wb_sel  in  SEL_WIDTH  pipeline destination register.
- pipe_wb_data  in  DATA_WIDTH  pipeline result.
- mc_issue_valid  in  1  multi-cycle op issued; reserves its destination.
- mc_issue_sel  in  SEL_WIDTH  reserved destination.
- mc_result_valid  in  1  multi-cycle result offered.
- mc_result_sel  in  SEL_WIDTH  result destination.
- mc_result_data  in  DATA_WIDTH  result value.
- mc_result_ready  out  1  FIFO can accept this cycle.
- busy_mask  out  NUM_REGS  bit r set means register r has a pending multi-cycle write.
- stall_req  out  1  pipeline must hold its writeback; FIFO has priority.
- rf_write_en  out  1  register-file write enable.
- rf_write_sel  out  SEL_WIDTH  register-file write select.
- rf_write_data  out  DATA_WIDTH  register-file write data.

Behaviour:
Reset (rst_n low, asynchronous):
- rf_write_en, rf_write_sel, rf_write_data all 0.
- busy_mask 0, stall_req 0.
- FIFO empty, starve counter 0.
- mc_result_ready forced 0 while rst_n is low.

FIFO handshake:
- mc_result_ready = (count != BUF_DEPTH), computed from the current count only. A pop in the same cycle does not free a slot early.
- Transfer occurs when mc_result_valid and mc_result_ready are both 1.
- A transfer with mc_result_sel == 0 is accepted and discarded (no push).
- Push and pop in the same cycle are legal; count is unchanged.

Arbitration, decided each cycle and registered into the rf_write_* outputs on the next edge:
- pipe_eff = pipe_wb_valid and pipe_wb_sel != 0 and not stall_req.
- If pipe_eff: load the pipeline write.
- Else if the FIFO is non-empty: pop the head and load it.
- Else: rf_write_en = 0; sel/data hold their previous values.
- When stall_req = 1, pipe_wb_valid is ignored; upstream holds its result until stall_req falls.
- A pipeline write to register 0 never occupies the port.

Latency:
- Pipeline: input at edge k, rf_write_en visible after edge k.
- Multi-cycle result: accepted at edge k, earliest rf_write_en after edge k+1. No FIFO bypass.

Scoreboard:
- On mc_issue_valid with sel != 0: set the bit.
- When a popped FIFO entry loads into rf_write_*: clear that entry's bit.
- Set and clear of the same bit in the same cycle: set wins.
- A pipeline write to a busy register is performed and busy_mask is unchanged; the WAW check belongs to decode.

Starvation:
- Counter increments (saturating) when the FIFO is non-empty and the pop is blocked by pipe_eff.
- Counter resets to 0 on any pop, or when the FIFO is empty.
- stall_req is registered: set on the edge the counter reaches STARVE_LIMIT; cleared on the edge after the FIFO becomes empty.

Reset mid-operation:
- Pending FIFO entries are discarded and busy bits cleared; no write is emitted after release.

Test Plan:
1. Pipeline only: pipe_wb_valid=1, sel=5, data=0xDEADBEEF at edge 1 -> rf_write_en=1, sel=5, data=0xDEADBEEF after edge 1; sel=0 -> rf_write_en stays 0.
2. Multi-cycle path: issue sel=3 -> busy_mask=0x0008; result sel=3, data=0x12345678 accepted at edge k, pipe idle -> rf write after edge k+1 and busy_mask=0x0000 on that edge.
3. FIFO full: two results pushed while pipe_wb_valid=1 every cycle -> mc_result_ready=0; a third offer is held; pipe drops for one cycle -> one pop, ready=1 next cycle.
4. Starvation: FIFO non-empty, pipe valid for 4 consecutive cycles -> stall_req=1; FIFO drains in order with pipe ignored; stall_req=0 the edge after empty.
5. Same-cycle issue to sel=7 while the popped entry for sel=7 completes -> busy bit 7 remains 1.
6. rst_n pulsed low asynchronously with 2 FIFO entries and busy_mask=0x00C0 -> all outputs 0 immediately; no rf write after release.
